// File: rtl/envelope_trig_pkg.sv
// Shared widths and FSM state type for the envelope power trigger.
// Imported by the top module and the sliding window accumulator.
package envelope_trig_pkg;

  localparam int NSAMPS   = 8;
  localparam int INBITS   = 12;
  localparam int SQBITS   = 23;
  localparam int BEATBITS = 26;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HOLDOFF
  } trig_state_t;

endpackage

// File: rtl/sliding_window_sum.sv
// Running sum of the last 2^WINDOW_LOG2 input words.
// A register delay line supplies the word leaving the window.
module sliding_window_sum
  import envelope_trig_pkg::*;
#(
  parameter int DATBITS     = BEATBITS,
  parameter int WINDOW_LOG2 = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DATBITS-1:0]             dat_i,
  output logic [DATBITS+WINDOW_LOG2-1:0] sum_o
);

  localparam int DEPTH   = 1 << WINDOW_LOG2;
  localparam int SUMBITS = DATBITS + WINDOW_LOG2;

  logic [DATBITS-1:0] dly_q [DEPTH];
  logic [SUMBITS-1:0] acc_q;

  // acc never drops below the oldest entry, so the subtract cannot wrap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        dly_q[i] <= '0;
      end
      acc_q <= '0;
    end else begin
      dly_q[0] <= dat_i;
      for (int i = 1; i < DEPTH; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
      acc_q <= acc_q
             + SUMBITS'(dat_i)
             - SUMBITS'(dly_q[DEPTH-1]);
    end
  end

  assign sum_o = acc_q;

endmodule

// File: rtl/envelope_power_trigger.sv
// Per-beat power, windowed sum and threshold trigger with holdoff.
// Squaring and adder tree live here; the window is a sub-module.
module envelope_power_trigger
  import envelope_trig_pkg::*;
#(
  parameter int INBITS      = 12,
  parameter int WINDOW_LOG2 = 2,
  parameter int HOLDBITS    = 16,
  parameter int CNTBITS     = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NSAMPS-1:0][INBITS-1:0]   dat_i,
  input  logic                            enable_i,
  input  logic [BEATBITS+WINDOW_LOG2-1:0] threshold_i,
  input  logic [HOLDBITS-1:0]             holdoff_i,
  output logic [BEATBITS+WINDOW_LOG2-1:0] power_o,
  output logic                            trig_o,
  output logic                            armed_o,
  output logic [CNTBITS-1:0]              trig_count_o
);

  localparam int PAIRBITS = SQBITS + 1;
  localparam int NPAIRS   = NSAMPS / 2;

  logic [NSAMPS-1:0][INBITS-1:0] dat_q;
  logic [NSAMPS-1:0][SQBITS-1:0] sq_d;
  logic [NSAMPS-1:0][SQBITS-1:0] sq_q;
  logic [NPAIRS-1:0][PAIRBITS-1:0] pair_q;
  logic [BEATBITS-1:0] beat_d;
  logic [BEATBITS-1:0] beat_q;

  // magnitude fits INBITS unsigned, even for the most negative code
  for (genvar i = 0; i < NSAMPS; i++) begin : g_sq
    logic [INBITS-1:0] mag;
    assign mag = dat_q[i][INBITS-1]
               ? (~dat_q[i] + INBITS'(1))
               : dat_q[i];
    assign sq_d[i] = SQBITS'(mag) * SQBITS'(mag);
  end

  always_comb begin
    beat_d = '0;
    for (int j = 0; j < NPAIRS; j++) begin
      beat_d = beat_d + BEATBITS'(pair_q[j]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_q  <= '0;
      sq_q   <= '0;
      pair_q <= '0;
      beat_q <= '0;
    end else begin
      dat_q <= dat_i;
      sq_q  <= sq_d;
      for (int j = 0; j < NPAIRS; j++) begin
        pair_q[j] <= PAIRBITS'(sq_q[2*j])
                   + PAIRBITS'(sq_q[2*j+1]);
      end
      beat_q <= beat_d;
    end
  end

  sliding_window_sum #(
    .DATBITS     (BEATBITS),
    .WINDOW_LOG2 (WINDOW_LOG2)
  ) u_window (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .dat_i (beat_q),
    .sum_o (power_o)
  );

  trig_state_t         state_q, state_d;
  logic [HOLDBITS-1:0] hcnt_q, hcnt_d;
  logic [CNTBITS-1:0]  cnt_q, cnt_d;
  logic                trig_q, trig_d;
  logic                above;

  assign above = power_o > threshold_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
    end
  end

  // disable wins over every other transition
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (above) begin
            trig_d  = 1'b1;
            hcnt_d  = holdoff_i;
            state_d = HOLDOFF;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNTBITS'(1);
            end
          end
        end
        HOLDOFF: begin
          if (hcnt_q == '0) begin
            state_d = ARMED;
          end else begin
            hcnt_d = hcnt_q - HOLDBITS'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign trig_o       = trig_q;
  assign armed_o      = (state_q == ARMED);
  assign trig_count_o = cnt_q;

endmodule

// File: tb/tb_envelope_power_trigger.sv
// Directed bench for envelope_power_trigger with a power scoreboard.
// Uses a 4-beat window and a 4-bit trigger counter.
module tb_envelope_power_trigger;

  localparam int WL = 2;
  localparam int NW = 1 << WL;
  localparam int PB = 26 + WL;
  localparam int CB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0][11:0] dat = '0;
  logic            enable = 1'b0;
  logic [PB-1:0]   threshold = '0;
  logic [15:0]     holdoff = '0;
  logic [PB-1:0]   power;
  logic            trig;
  logic            armed;
  logic [CB-1:0]   tcount;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  longint      hist[$];
  logic [63:0] exp_q[$];
  int          trig_cyc[$];

  always #5 clk = ~clk;

  envelope_power_trigger #(
    .INBITS      (12),
    .WINDOW_LOG2 (WL),
    .HOLDBITS    (16),
    .CNTBITS     (CB)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .dat_i        (dat),
    .enable_i     (enable),
    .threshold_i  (threshold),
    .holdoff_i    (holdoff),
    .power_o      (power),
    .trig_o       (trig),
    .armed_o      (armed),
    .trig_count_o (tcount)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0][11:0] fill(input logic [11:0] v);
    logic [7:0][11:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  // model power of the beat, push the window sum it will produce
  task automatic step(input logic [7:0][11:0] d);
    longint p;
    longint w;
    longint s;
    p = 0;
    w = 0;
    for (int i = 0; i < 8; i++) begin
      s = longint'($signed(d[i]));
      p += s * s;
    end
    hist.push_back(p);
    if (hist.size() > NW) void'(hist.pop_front());
    foreach (hist[i]) w += hist[i];
    exp_q.push_back(64'(w));
    dat = d;
    @(posedge clk);
    #1;
    cyc++;
    chk("power", 64'(power), exp_q.pop_front());
    if (trig) trig_cyc.push_back(cyc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dat = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk("rst_power", 64'(power), 64'd0);
    chk("rst_trig", 64'(trig), 64'd0);
    chk("rst_armed", 64'(armed), 64'd0);
    chk("rst_count", 64'(tcount), 64'd0);
    hist.delete();
    exp_q.delete();
    repeat (4) exp_q.push_back(64'd0);
    trig_cyc.delete();
  endtask

  initial begin
    logic [7:0][11:0] imp;

    // constant DC, retrigger every 12 cycles
    enable = 1'b1;
    threshold = PB'(319999);
    holdoff = 16'd10;
    do_reset();
    repeat (50) step(fill(12'd100));
    chk("dc_ntrig", 64'(trig_cyc.size()), 64'd4);
    for (int i = 0; i < trig_cyc.size() && i < 4; i++)
      chk("dc_trig_cyc", 64'(trig_cyc[i]), 64'(9 + 12 * i));
    chk("dc_count", 64'(tcount), 64'd4);

    // threshold equal to power: never fires
    threshold = PB'(320000);
    do_reset();
    repeat (30) step(fill(12'd100));
    chk("eq_ntrig", 64'(trig_cyc.size()), 64'd0);
    chk("eq_count", 64'(tcount), 64'd0);
    chk("eq_armed", 64'(armed), 64'd1);

    // full scale negative
    threshold = '1;
    do_reset();
    repeat (100) step(fill(12'h800));
    chk("fs_power", 64'(power), 64'd134217728);
    chk("fs_count", 64'(tcount), 64'd0);

    // impulse latency and holdoff 0 retrigger
    threshold = PB'(999999);
    holdoff = 16'd0;
    do_reset();
    repeat (3) step('0);
    imp = '0;
    imp[0] = 12'd1000;
    step(imp);
    repeat (12) step('0);
    chk("imp_ntrig", 64'(trig_cyc.size()), 64'd2);
    if (trig_cyc.size() == 2) begin
      chk("imp_trig0", 64'(trig_cyc[0]), 64'd9);
      chk("imp_trig1", 64'(trig_cyc[1]), 64'd11);
    end
    chk("imp_count", 64'(tcount), 64'd2);

    // enable drop in the middle of a long holdoff
    threshold = PB'(319999);
    holdoff = 16'd50;
    do_reset();
    repeat (14) step(fill(12'd100));
    chk("ho_count", 64'(tcount), 64'd1);
    chk("ho_armed", 64'(armed), 64'd0);
    enable = 1'b0;
    step(fill(12'd100));
    chk("off_armed", 64'(armed), 64'd0);
    chk("off_count", 64'(tcount), 64'd1);
    chk("off_trig", 64'(trig), 64'd0);
    step(fill(12'd100));
    chk("off2_armed", 64'(armed), 64'd0);
    enable = 1'b1;
    step(fill(12'd100));
    chk("on_armed", 64'(armed), 64'd1);
    chk("on_trig", 64'(trig), 64'd0);
    step(fill(12'd100));
    chk("re_trig", 64'(trig), 64'd1);
    chk("re_count", 64'(tcount), 64'd2);

    // counter saturation, then reset mid-window
    holdoff = 16'd0;
    do_reset();
    repeat (60) step(fill(12'd100));
    chk("sat_count", 64'(tcount), 64'd15);
    chk("sat_ntrig", 64'(trig_cyc.size()), 64'd26);
    for (int i = 1; i < trig_cyc.size(); i++)
      chk("sat_spacing", 64'(trig_cyc[i] - trig_cyc[i-1]), 64'd2);
    do_reset();
    repeat (8) step('0);
    chk("post_count", 64'(tcount), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/envelope_power_trigger.md
Name: envelope_power_trigger

Overview:
- Sits directly downstream of the 8-sample super-sample-rate lowpass filter and consumes its 8×12-bit signed output beat every clock.
- Per beat, computes the instantaneous power (sum of squares of all 8 samples).
- Keeps a sliding-window sum of that power over 2^WINDOW_LOG2 beats.
- Compares the window sum against a programmable threshold and runs an arm/trigger/holdoff state machine that emits single-cycle trigger pulses and a trigger count for the event-capture logic.

Parameters:
- INBITS, 12, signed sample width, matching the filter output.
- NSAMPS, 8, samples per clock beat; fixed, not overridable.
- WINDOW_LOG2, 2, log2 of the sliding-window length in beats (legal range 0..4).
- HOLDBITS, 16, width of the holdoff counter.
- CNTBITS, 16, width of the trigger counter.

Ports:
- clk_i  in  1  system clock; one clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- dat_i  in  NSAMPS×INBITS  packed signed samples from the lowpass filter, [NSAMPS-1:0][INBITS-1:0].
- enable_i  in  1  arm enable (level).
- threshold_i  in  26+WINDOW_LOG2  unsigned window-power threshold.
- holdoff_i  in  HOLDBITS  holdoff length in beats after a trigger.
- power_o  out  26+WINDOW_LOG2  unsigned sliding-window power sum.
- trig_o  out  1  single-cycle trigger pulse.
- armed_o  out  1  high while the FSM is in ARMED.
- trig_count_o  out  CNTBITS  saturating trigger count.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - power_o=0, trig_o=0, armed_o=0, trig_count_o=0.
  - All pipeline registers and the window delay line are cleared.
  - FSM goes to IDLE.
- Pipeline, for a beat presented at edge k:
  - k+1: input registered.
  - k+2: each sample squared into an unsigned 23-bit value (max (-2048)^2 = 4194304).
  - k+3: pairwise sums, 24 bits.
  - k+4: beat power P, the full 8-sample sum, 26 bits.
  - k+5: window accumulator updated as acc <= acc + P_new - P_delayed, where P_delayed is P from 2^WINDOW_LOG2 beats earlier, taken from a zero-initialised delay line.
  - power_o equals acc and is visible from edge k+5.
  - No overflow is possible: full scale is 2^(25+WINDOW_LOG2) < 2^(26+WINDOW_LOG2).
- Pipeline is free-running and independent of the FSM and enable_i.
- WINDOW_LOG2=0: acc simply equals P, one cycle later.
- FSM states: IDLE, ARMED, HOLDOFF. Transitions are evaluated every edge.
  - enable_i=0 in any state: next state IDLE, trig_o=0, hold counter cleared. This has priority over all other transitions.
  - IDLE with enable_i=1 goes to ARMED.
  - ARMED with power_o > threshold_i (strictly greater):
    - trig_o <= 1 for one cycle;
    - trig_count_o increments, saturating at all-ones;
    - hcnt <= holdoff_i;
    - next state HOLDOFF.
  - ARMED otherwise: stay in ARMED.
  - HOLDOFF with hcnt==0 goes to ARMED; otherwise hcnt decrements.
  - HOLDOFF therefore lasts holdoff_i+1 cycles, so the minimum retrigger spacing is 2 cycles.
- trig_o is never high in two consecutive cycles.
- armed_o is registered and equals (state==ARMED).
- holdoff_i is sampled only at the trigger edge. threshold_i is used live.
- trig_count_o holds its value across enable toggles; only rst_i clears it.
- Reset asserted mid-holdoff or mid-window: everything clears on that edge, including the window contents, so power_o restarts from 0.

Decomposition:
- Shared package envelope_trig_pkg holds:
  - localparams NSAMPS=8, INBITS=12, SQBITS=23, BEATBITS=26;
  - typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF} trig_state_t.
- One sub-module, sliding_window_sum (parameters DATBITS, WINDOW_LOG2; ports clk_i, rst_i, dat_i, sum_o).
  - Contains the delay line as an explicit register chain, which synthesis may map to SRLs.
  - Contains the add/subtract accumulator.
  - rst_i clears both the delay line and the accumulator.
- Squaring and the adder tree stay in the top module.

Test Plan:
- Constant DC: all samples = 100, threshold 319999, holdoff 10, enable high.
  - P = 80000; power_o settles at 320000 on edge 8 after the first beat.
  - trig_o pulses every 12 cycles while the input persists.
  - With threshold 320000: no triggers at all.
- Full scale: all samples = -2048, WINDOW_LOG2=2.
  - power_o = 134217728.
  - No wrap over 100 beats.
- Impulse latency: one beat with sample 0 = 1000, all other samples and beats = 0; threshold 999999, holdoff 0.
  - power_o = 1000000 on edges k+5 through k+8, then 0.
  - trig_o high at k+6 and k+8 only; trig_count_o = 2.
- Enable drop mid-holdoff: trigger with holdoff 50, then drop enable_i 5 cycles later.
  - FSM goes to IDLE next edge; armed_o = 0; count retained.
  - Re-enable gives ARMED one cycle later and an immediate retrigger if still above threshold.
- Saturation and reset: CNTBITS=4, drive 20 triggers.
  - trig_count_o sticks at 15.
  - Pulse rst_i during a nonzero window: power_o = 0 and trig_count_o = 0 on the next edge.
  - Zero input after reset keeps power_o = 0, proving the delay line was cleared.
